// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared constants, lock FSM states and step helper for clkgen_ce_multi
package clkgen_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int CHAN_SEL_W = 3;
  typedef enum logic {ST_COUNTING, ST_LOCKED} lock_state_e;
  function automatic int lock_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic logic [63:0] calc_step(input longint unsigned f_in_hz, input longint unsigned f_out_hz,
                                            input int acc_w = ACC_W_DEF);
    return ((f_out_hz << acc_w) + f_in_hz / 2) / f_in_hz;
  endfunction
endpackage

// File: rtl/clkgen_ce_multi_chan.sv
// phase_acc_chan: one fractional-rate CE channel (step register, phase accumulator, carry->CE flop).
// CLKGEN_SQUARE_EN adds a CE-driven divide-by-2 square output; otherwise sq_o is tied low.
module phase_acc_chan
  import clkgen_pkg::*;
#(
  parameter int              ACC_W        = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_STEP = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             run_i,
  input  logic [ACC_W-1:0] step_i,
  output logic             ce_o,
  output logic             sq_o
);
  logic [ACC_W-1:0] step_q, step_d, acc_q, acc_d;
  logic             ce_q, ce_d;
  always_comb begin
    step_d        = we_i ? step_i : step_q;
    {ce_d, acc_d} = run_i ? {1'b0, acc_q} + {1'b0, step_q} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= DEFAULT_STEP;
      acc_q  <= '0;
      ce_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
      ce_q   <= ce_d;
    end
  end
  assign ce_o = ce_q;
`ifdef CLKGEN_SQUARE_EN
  logic sq_q;
  always_ff @(posedge clk) sq_q <= rst ? 1'b0 : sq_q ^ ce_q;
  assign sq_o = sq_q;
`else
  assign sq_o = 1'b0;
`endif
endmodule

// File: rtl/clkgen_ce_multi.sv
// clkgen_ce_multi: N phase-aligned fractional clock-enable generators with an MMCM-style lock model.
// Define CLKGEN_SQUARE_EN to get toggling CLK_SQ outputs; otherwise CLK_SQ is all zeros.
module clkgen_ce_multi
  import clkgen_pkg::*;
#(
  parameter int               NCHAN        = 2,
  parameter int               ACC_W        = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_STEP = {1'b1, {(ACC_W-1){1'b0}}},
  parameter int               LOCK_CYCLES  = 16
) (
  input  logic                  CLK_IN1,
  input  logic                  RST,
  input  logic                  CFG_WE,
  input  logic [CHAN_SEL_W-1:0] CFG_SEL,
  input  logic [ACC_W-1:0]      CFG_STEP,
  output logic [NCHAN-1:0]      CE_OUT,
  output logic                  LOCKED,
  output logic [NCHAN-1:0]      CLK_SQ
);
  localparam int CNT_W = lock_cnt_w(LOCK_CYCLES);
  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr, run;
  assign wr = CFG_WE && (32'(CFG_SEL) < NCHAN);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr) begin
      state_d = ST_COUNTING;
      cnt_d   = '0;
    end else if (state_q == ST_COUNTING) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_d == CNT_W'(LOCK_CYCLES)) ? ST_LOCKED : ST_COUNTING;
    end
  end
  always_ff @(posedge CLK_IN1) begin
    if (RST) begin
      state_q <= ST_COUNTING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign LOCKED = (state_q == ST_LOCKED);
  // any accepted write clears every accumulator on the same edge so channels restart aligned
  assign run = LOCKED && !wr;
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    phase_acc_chan #(.ACC_W(ACC_W), .DEFAULT_STEP(DEFAULT_STEP)) u_chan (
      .clk   (CLK_IN1),
      .rst   (RST),
      .we_i  (wr && (32'(CFG_SEL) == i)),
      .run_i (run),
      .step_i(CFG_STEP),
      .ce_o  (CE_OUT[i]),
      .sq_o  (CLK_SQ[i])
    );
  end
endmodule

// File: tb/tb_clkgen_ce_multi.sv
// tb_clkgen_ce_multi: directed scoreboard bench for clkgen_ce_multi (NCHAN=2, ACC_W=32, LOCK_CYCLES=16).
module tb_clkgen_ce_multi;
  logic        clk = 0, rst = 1, we = 0;
  logic [2:0]  sel = 0;
  logic [31:0] stp = 0;
  logic [1:0]  ce, sq, sq_exp, pce;
  logic        locked;
  logic [31:0] s0, s1;
  int          passed = 0, total = 0;
  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  clkgen_ce_multi dut (
    .CLK_IN1(clk), .RST(rst), .CFG_WE(we), .CFG_SEL(sel), .CFG_STEP(stp),
    .CE_OUT(ce), .LOCKED(locked), .CLK_SQ(sq)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string t, input logic [31:0] e);
    sb_t x;
    x.tag = t;
    x.exp = e;
    sb.push_back(x);
  endtask
  task automatic check(input logic [31:0] obs);
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%0h expected=entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
  endtask
  // CE after edge k: did floor(k*step/2^32) advance?
  function automatic logic exp_ce(input logic [31:0] s, input int k);
    logic [63:0] a, b;
    a = 64'(s) * 64'(k);
    b = 64'(s) * 64'(k - 1);
    return a[63:32] != b[63:32];
  endfunction
  task automatic wait_lock(input string t);
    int n;
    n = 0;
    push(t, 16);
    while (!locked && n < 200) begin
      tick;
      n++;
    end
    check(n);
  endtask
  task automatic cfg_write(input logic [2:0] c, input logic [31:0] v);
    we  = 1;
    sel = c;
    stp = v;
    push("wr_locked_drop", 0);
    push("wr_ce_clear", 0);
    tick;
    we = 0;
    check({31'b0, locked});
    check({30'b0, ce});
  endtask
  task automatic run_pat(input int k0, input int n, input bit chk_sq);
    logic [1:0] e;
    for (int k = k0; k < k0 + n; k++) begin
      e = {exp_ce(s1, k), exp_ce(s0, k)};
      sq_exp ^= pce;
      pce = e;
      push($sformatf("ce_k%0d", k), {30'b0, e});
      push("locked_run", 1);
`ifdef CLKGEN_SQUARE_EN
      if (chk_sq) push($sformatf("sq_k%0d", k), {30'b0, sq_exp});
`else
      if (chk_sq) push($sformatf("sq_k%0d", k), 0);
`endif
      tick;
      we = 0;
      check({30'b0, ce});
      check({31'b0, locked});
      if (chk_sq) check({30'b0, sq});
    end
  endtask
  initial begin
    int c0, c1;
    s0 = 32'h8000_0000;
    s1 = 32'h8000_0000;
    push("rst_locked", 0);
    push("rst_ce", 0);
    push("rst_sq", 0);
    repeat (3) tick;
    check({31'b0, locked});
    check({30'b0, ce});
    check({30'b0, sq});
    rst = 0;
    wait_lock("lock_after_rst");
    run_pat(1, 8, 0);
    cfg_write(1, 32'h5555_5556);
    s1 = 32'h5555_5556;
    wait_lock("relock_ch1");
    run_pat(1, 12, 0);
    we  = 1;
    sel = 5;
    stp = 32'h0;
    run_pat(13, 12, 0);
    cfg_write(0, 32'h0);
    s0 = 32'h0;
    wait_lock("relock_step0");
    c0 = 0;
    c1 = 0;
    push("step0_pulses", 0);
    push("ch1_pulses", 32'((64'(s1) * 64'd1000) >> 32));
    repeat (1000) begin
      tick;
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    check(c0);
    check(c1);
    cfg_write(0, 32'hFFFF_FFFF);
    s0 = 32'hFFFF_FFFF;
    wait_lock("relock_max");
    run_pat(1, 10, 0);
    rst = 1;
    we  = 1;
    sel = 0;
    stp = 32'h1234;
    push("rst_mid_locked", 0);
    push("rst_mid_ce", 0);
    push("rst_mid_sq", 0);
    tick;
    rst = 0;
    we  = 0;
    check({31'b0, locked});
    check({30'b0, ce});
    check({30'b0, sq});
    s0 = 32'h8000_0000;
    s1 = 32'h8000_0000;
    wait_lock("relock_rst");
    sq_exp = 0;
    pce    = 0;
    run_pat(1, 12, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
